// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;
  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  // One guard bit above the partial remainder turns the borrow into a sign bit.
  always_comb begin
    shifted = {rem_in, next_bit};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[DIVISOR_W+1];
    rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  busy
);
  localparam int CW = cnt_w(DIVIDEND_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIVIDEND_W - 1);

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic                  unused_rem_msb;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in   (rem_q),
    .next_bit (dvd_q[DIVIDEND_W-1]),
    .divisor  (dsr_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // dvd_q doubles as the quotient: dividend bits shift out the top as quotient bits enter below.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          dsr_d = divisor;
          if (divisor == '0) begin
            dvd_d   = '1;
            rem_d   = {1'b0, dividend[DIVISOR_W-1:0]};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode straight from the state flop, so reset clears them with no glitch.
  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign quotient       = dvd_q;
  assign remainder      = rem_q[DIVISOR_W-1:0];
  assign div_by_zero    = dbz_q;
  assign unused_rem_msb = rem_q[DIVISOR_W];
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider against hand-computed results.
module tb_seq_restoring_divider;
  logic       clk, rst;
  logic       in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [7:0] dividend, quotient;
  logic [3:0] divisor, remainder;

  int n_chk = 0;
  int n_err = 0;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dsr;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;   // edges after the accept edge until out_valid is seen
    int         hold;  // cycles out_ready stays low in DONE
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Shift-and-add model of the 4-bit array multiplier, widened for an 8-bit quotient.
  function automatic logic [11:0] mul(input logic [7:0] a, input logic [3:0] b);
    logic [11:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) acc = acc + ({4'b0000, a} << i);
    return acc;
  endfunction

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input int hold,
                        output logic [7:0] q, output logic [3:0] r, output logic z,
                        output int lat);
    check("in_ready_idle", int'(in_ready), 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", int'(out_valid), 1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    check("busy_done", int'(busy), 1);
    check("in_ready_done", int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      dividend = 8'd1;
      divisor  = 4'd1;
      @(posedge clk); #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_q", int'(quotient), int'(q));
      check("hold_r", int'(remainder), int'(r));
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[11];
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;

    tbl[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8, 0};
    tbl[1]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8, 0};
    tbl[2]  = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 8, 0};
    // A zero divisor goes straight to DONE on the accept edge.
    tbl[3]  = '{8'h5A,  4'd0,  8'hFF,  4'hA,  1'b1, 0, 0};
    tbl[4]  = '{8'd100, 4'd3,  8'd33,  4'd1,  1'b0, 8, 5};
    tbl[5]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8, 1};
    tbl[6]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 8, 0};
    tbl[7]  = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 8, 2};
    tbl[8]  = '{8'd128, 4'd11, 8'd11,  4'd7,  1'b0, 8, 0};
    tbl[9]  = '{8'd0,   4'd0,  8'hFF,  4'd0,  1'b1, 0, 3};
    tbl[10] = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0, 8, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_div(tbl[i].dvd, tbl[i].dsr, tbl[i].hold, q, r, z, lat);
      check($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].q));
      check($sformatf("vec%0d_r", i), int'(r), int'(tbl[i].r));
      check($sformatf("vec%0d_dbz", i), int'(z), int'(tbl[i].dbz));
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Reset during CALC step 4 of 200/7 must abort immediately.
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_div(8'd9, 4'd2, 0, q, r, z, lat);
    check("post_rst_q", int'(q), 4);
    check("post_rst_r", int'(r), 1);
    check("post_rst_lat", lat, 8);

    // Every dividend against every non-zero divisor, back to back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(8'(a), 4'(b), int'($urandom_range(0, 2)), q, r, z, lat);
        check("exh_identity", int'(mul(q, 4'(b))) + int'(r), a);
        check("exh_rem_lt", int'(r < 4'(b)), 1);
        check("exh_dbz", int'(z), 0);
        check("exh_lat", lat, 8);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
